// File: rtl/cmos_dvp_pattern_tx.sv
// Synthetic DVP camera source: CMOS-style vsync/href framing with selectable
// 8-bit test patterns, used in place of a real sensor on the capture path.
module cmos_dvp_pattern_tx #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_BLANK   = 160,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned VSYNC_LOW = 4,
  parameter int unsigned V_FRONT   = 2,
  parameter int unsigned V_BACK    = 2
) (
  input  logic        i_clk_cmos,
  input  logic        i_rst_n,
  input  logic        i_enable,
  input  logic [1:0]  i_pattern_sel,
  output logic        o_cmos_vsync,
  output logic        o_cmos_href,
  output logic [7:0]  o_cmos_data,
  output logic        o_frame_done,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy
);

  localparam int unsigned CW  = 12;
  localparam int unsigned DW  = 8;
  localparam int unsigned FCW = 16;
  localparam int unsigned PW  = 2;

  localparam logic [CW-1:0] X_LAST   = CW'(H_ACTIVE + H_BLANK - 1);
  localparam logic [CW-1:0] X_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] VS_LAST  = CW'(VSYNC_LOW - 1);
  localparam logic [CW-1:0] VF_LAST  = CW'(V_FRONT - 1);
  localparam logic [CW-1:0] VA_LAST  = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] VB_LAST  = CW'(V_BACK - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VS_LOW,
    ST_V_FRONT,
    ST_ACTIVE,
    ST_V_BACK
  } state_t;

  state_t          state_q, state_n;
  logic [CW-1:0]   x_q, x_n;
  logic [CW-1:0]   ln_q, ln_n;
  logic [CW-1:0]   ln_last;
  logic [PW-1:0]   pat_q;
  logic [DW-1:0]   base_q;
  logic            frame_start;
  logic            vsync_n;
  logic            href_n;
  logic [DW-1:0]   data_n;
  logic            done_n;

  // Next-state and next-output decode; outputs are computed for the clock
  // about to be launched so every output registers on the same edge as state.
  always_comb begin
    state_n     = state_q;
    x_n         = x_q;
    ln_n        = ln_q;
    ln_last     = '0;
    frame_start = 1'b0;
    vsync_n     = 1'b0;
    href_n      = 1'b0;
    data_n      = '0;
    done_n      = 1'b0;

    case (state_q)
      ST_VS_LOW:  ln_last = VS_LAST;
      ST_V_FRONT: ln_last = VF_LAST;
      ST_ACTIVE:  ln_last = VA_LAST;
      ST_V_BACK:  ln_last = VB_LAST;
      default:    ln_last = '0;
    endcase

    if (state_q == ST_IDLE) begin
      x_n  = '0;
      ln_n = '0;
      if (i_enable) state_n = ST_VS_LOW;
    end else if (x_q == X_LAST) begin
      x_n = '0;
      if (ln_q == ln_last) begin
        ln_n = '0;
        case (state_q)
          ST_VS_LOW:  state_n = ST_V_FRONT;
          ST_V_FRONT: state_n = ST_ACTIVE;
          ST_ACTIVE:  state_n = ST_V_BACK;
          ST_V_BACK:  state_n = i_enable ? ST_VS_LOW : ST_IDLE;
          default:    state_n = ST_IDLE;
        endcase
      end else begin
        ln_n = ln_q + CW'(1);
      end
    end else begin
      x_n = x_q + CW'(1);
    end

    frame_start = (state_n == ST_VS_LOW) &&
                  ((state_q == ST_IDLE) || (state_q == ST_V_BACK));
    vsync_n     = (state_n == ST_V_FRONT) || (state_n == ST_ACTIVE) ||
                  (state_n == ST_V_BACK);
    href_n      = (state_n == ST_ACTIVE) && (x_n < X_ACT);
    done_n      = (state_n == ST_V_BACK) && (x_n == X_LAST) && (ln_n == VB_LAST);

    // Line counter doubles as y while in ACTIVE.
    if (href_n) begin
      case (pat_q)
        2'd0:    data_n = x_n[DW-1:0];
        2'd1:    data_n = ln_n[DW-1:0];
        2'd2:    data_n = {DW{x_n[3] ^ ln_n[3]}};
        default: data_n = x_n[DW-1:0] + ln_n[DW-1:0] + base_q;
      endcase
    end
  end

  always_ff @(posedge i_clk_cmos) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      x_q          <= '0;
      ln_q         <= '0;
      pat_q        <= '0;
      base_q       <= '0;
      o_cmos_vsync <= 1'b0;
      o_cmos_href  <= 1'b0;
      o_cmos_data  <= '0;
      o_frame_done <= 1'b0;
      o_frame_cnt  <= '0;
      o_busy       <= 1'b0;
    end else begin
      state_q      <= state_n;
      x_q          <= x_n;
      ln_q         <= ln_n;
      // Count has already advanced on the previous frame's last clock.
      if (frame_start) begin
        pat_q  <= i_pattern_sel;
        base_q <= o_frame_cnt[DW-1:0];
      end
      o_cmos_vsync <= vsync_n;
      o_cmos_href  <= href_n;
      o_cmos_data  <= data_n;
      o_frame_done <= done_n;
      if (done_n) o_frame_cnt <= o_frame_cnt + FCW'(1);
      o_busy       <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_cmos_dvp_pattern_tx.sv
// Bench for cmos_dvp_pattern_tx: per-clock comparison against a frame model
// derived from clock index within the frame.
module tb_cmos_dvp_pattern_tx;

  localparam int HA = 8, HB = 4, VA = 4, VS = 1, VF = 1, VB = 1;
  localparam int HT = HA + HB;
  localparam int FRAME = (VS + VF + VA + VB) * HT;

  localparam int D_HA = 640, D_HT = 800, D_VS = 4, D_VF = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable, enable2;
  logic [1:0]  sel, sel2;
  logic        vsync, href, done, busy;
  logic [7:0]  data;
  logic [15:0] cnt;
  logic        vsync2, href2, done2, busy2;
  logic [7:0]  data2;
  logic [15:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;
  int frame_no = 0;
  int cur_sel;
  int ns;

  always #5 clk = ~clk;

  cmos_dvp_pattern_tx #(
    .H_ACTIVE(HA), .H_BLANK(HB), .V_ACTIVE(VA),
    .VSYNC_LOW(VS), .V_FRONT(VF), .V_BACK(VB)
  ) dut (
    .i_clk_cmos(clk), .i_rst_n(rst_n), .i_enable(enable), .i_pattern_sel(sel),
    .o_cmos_vsync(vsync), .o_cmos_href(href), .o_cmos_data(data),
    .o_frame_done(done), .o_frame_cnt(cnt), .o_busy(busy)
  );

  cmos_dvp_pattern_tx dut2 (
    .i_clk_cmos(clk), .i_rst_n(rst_n), .i_enable(enable2), .i_pattern_sel(sel2),
    .o_cmos_vsync(vsync2), .o_cmos_href(href2), .o_cmos_data(data2),
    .o_frame_done(done2), .o_frame_cnt(cnt2), .o_busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_data(input int p, input int x, input int y, input int base);
    case (p)
      0:       return x % 256;
      1:       return y % 256;
      2:       return (((x / 8) % 2) != ((y / 8) % 2)) ? 255 : 0;
      default: return (x + y + base) % 256;
    endcase
  endfunction

  // One frame on dut; optional actions after checking clock t:
  // drop enable, change select, or assert reset (frame abandoned).
  task automatic run_frame(input int p, input int drop_t, input int sel_t,
                           input int new_sel, input int rst_t);
    int base, L, x, y, e_vs, e_href, e_data, e_done;
    string tg;
    base = exp_cnt;
    for (int t = 0; t < FRAME; t++) begin
      @(posedge clk); #1;
      L = t / HT;
      x = t % HT;
      y = L - (VS + VF);
      e_vs   = (L >= VS) ? 1 : 0;
      e_href = (L >= VS + VF && L < VS + VF + VA && x < HA) ? 1 : 0;
      e_data = e_href ? exp_data(p, x, y, base) : 0;
      e_done = (t == FRAME - 1) ? 1 : 0;
      if (e_done) exp_cnt = (exp_cnt + 1) % 65536;
      tg = $sformatf("fr%0d t%0d", frame_no, t);
      chk({tg, " vsync"}, 32'(vsync), 32'(e_vs));
      chk({tg, " href"},  32'(href),  32'(e_href));
      chk({tg, " data"},  32'(data),  32'(e_data));
      chk({tg, " done"},  32'(done),  32'(e_done));
      chk({tg, " busy"},  32'(busy),  32'd1);
      chk({tg, " cnt"},   32'(cnt),   32'(exp_cnt));
      if (t == drop_t) enable = 1'b0;
      if (t == sel_t) sel = 2'(new_sel);
      if (t == rst_t) begin
        rst_n = 1'b0;
        frame_no++;
        return;
      end
    end
    frame_no++;
  endtask

  task automatic idle_check(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk($sformatf("%s %0d vsync", name, i), 32'(vsync), 32'd0);
      chk($sformatf("%s %0d href", name, i),  32'(href),  32'd0);
      chk($sformatf("%s %0d data", name, i),  32'(data),  32'd0);
      chk($sformatf("%s %0d done", name, i),  32'(done),  32'd0);
      chk($sformatf("%s %0d busy", name, i),  32'(busy),  32'd0);
      chk($sformatf("%s %0d cnt", name, i),   32'(cnt),   32'(exp_cnt));
    end
  endtask

  initial begin
    int L, x, y, e_href;
    rst_n = 1'b0; enable = 1'b0; enable2 = 1'b0; sel = 2'd0; sel2 = 2'd0;

    // Reset state, then idle with enable low
    idle_check(3, "reset");
    rst_n = 1'b1;
    idle_check(3, "idle");

    // Ramp frame with select switched to pattern 1 mid-frame
    enable = 1'b1; sel = 2'd0;
    run_frame(0, -1, 40, 1, -1);
    run_frame(1, -1, 50, 3, -1);

    // Pattern 3 back-to-back
    for (int k = 0; k < 3; k++) run_frame(3, -1, -1, 0, -1);
    cur_sel = 3;

    // Random select changes at random points
    for (int k = 0; k < 4; k++) begin
      ns = int'($urandom_range(0, 3));
      run_frame(cur_sel, -1, int'($urandom_range(0, FRAME - 1)), ns, -1);
      cur_sel = ns;
    end

    // Stop request at clock 30 completes the frame, then idle
    run_frame(cur_sel, 29, -1, 0, -1);
    idle_check(20, "stop30");

    // Stop at a random clock
    sel = 2'(int'($urandom_range(0, 3)));
    cur_sel = int'(sel);
    enable = 1'b1;
    run_frame(cur_sel, int'($urandom_range(0, FRAME - 1)), -1, 0, -1);
    idle_check(5, "stoprnd");

    // Reset during the second active line
    sel = 2'd2; enable = 1'b1;
    run_frame(2, -1, -1, 0, int'($urandom_range(3 * HT, 4 * HT - 1)));
    exp_cnt = 0;
    @(posedge clk); #1;
    chk("rst vsync", 32'(vsync), 32'd0);
    chk("rst href",  32'(href),  32'd0);
    chk("rst data",  32'(data),  32'd0);
    chk("rst done",  32'(done),  32'd0);
    chk("rst busy",  32'(busy),  32'd0);
    chk("rst cnt",   32'(cnt),   32'd0);
    rst_n = 1'b1;
    run_frame(2, int'($urandom_range(0, FRAME - 1)), -1, 0, -1);
    idle_check(3, "postrst");

    // Frame counter wrap from 0xFFFF
    force dut.o_frame_cnt = 16'hFFFF;
    #1;
    release dut.o_frame_cnt;
    exp_cnt = 65535;
    idle_check(2, "preload");
    sel = 2'd3; enable = 1'b1;
    run_frame(3, 5, -1, 0, -1);
    idle_check(3, "wrap");

    // Checkerboard on default geometry, through line y=8
    sel2 = 2'd2; enable2 = 1'b1;
    for (int t = 0; t < (D_VS + D_VF + 9) * D_HT; t++) begin
      @(posedge clk); #1;
      enable2 = 1'b0;
      L = t / D_HT;
      x = t % D_HT;
      y = L - (D_VS + D_VF);
      e_href = (L >= D_VS + D_VF && x < D_HA) ? 1 : 0;
      chk($sformatf("cb t%0d vsync", t), 32'(vsync2), 32'((L >= D_VS) ? 1 : 0));
      chk($sformatf("cb t%0d href", t),  32'(href2),  32'(e_href));
      chk($sformatf("cb t%0d data", t),  32'(data2),
          32'(e_href ? exp_data(2, x, y, 0) : 0));
    end
    chk("cb busy", 32'(busy2), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cmos_dvp_pattern_tx.md
# cmos_dvp_pattern_tx

Synthetic DVP camera source. Generates CMOS-sensor-style frames: vsync high while the frame is valid, href high per active line, and 8-bit pixel data from a selectable test pattern. All outputs change on one clock. Drives the capture path in place of a real sensor for bring-up, loopback self-test and simulation benches.

## Interface
- H_ACTIVE, 640: pixels (href-high clocks) per active line
- H_BLANK, 160: href-low clocks after each line's active part
- V_ACTIVE, 480: active lines per frame
- VSYNC_LOW, 4: lines with vsync low at frame start
- V_FRONT, 2: vsync-high lines before the first active line
- V_BACK, 2: vsync-high lines after the last active line
- i_clk_cmos  in  1  pixel clock; all outputs launch on its rising edge
- i_rst_n  in  1  reset, synchronous, active-low
- i_enable  in  1  level; 1 = run frames continuously, 0 = stop after the current frame
- i_pattern_sel  in  2  pattern select, sampled at frame start
- o_cmos_vsync  out  1  frame valid (high), frame sync (low)
- o_cmos_href  out  1  line data valid
- o_cmos_data  out  8  pixel data; 0 whenever href is low
- o_frame_done  out  1  one-clock pulse on the last clock of each frame
- o_frame_cnt  out  16  completed frames, wraps at 0xFFFF -> 0
- o_busy  out  1  high while a frame is in progress

## Operation
- H_TOTAL = H_ACTIVE + H_BLANK. Every parameter is at least 1 and H_TOTAL is at most 4095. Column counter x and line counter y are 12 bits.
- FSM states: IDLE -> VS_LOW -> V_FRONT -> ACTIVE -> V_BACK -> (VS_LOW if i_enable, else IDLE).
- Each non-IDLE state lasts exactly its parameter count in lines of H_TOTAL clocks: VS_LOW uses VSYNC_LOW, V_FRONT uses V_FRONT, ACTIVE uses V_ACTIVE, V_BACK uses V_BACK.
- The x counter runs 0..H_TOTAL-1 in every non-IDLE state. The y counter counts lines within ACTIVE only (0..V_ACTIVE-1).
- Output levels by state:
  - IDLE: vsync 0, href 0, data 0.
  - VS_LOW: vsync 0.
  - V_FRONT, ACTIVE, V_BACK: vsync 1.
  - href is 1 only in ACTIVE with x < H_ACTIVE.
- Patterns (latched pattern p, pixel at x, y):
  - 0: data = x[7:0]
  - 1: data = y[7:0]
  - 2: data = (x[3] ^ y[3]) ? 8'hFF : 8'h00
  - 3: data = (x + y + o_frame_cnt[7:0]) mod 256, using the count value at frame start
- i_pattern_sel is latched on the IDLE->VS_LOW and V_BACK->VS_LOW transitions. Mid-frame changes have no effect.
- Dropping i_enable mid-frame never truncates the frame. The current frame completes, then the FSM enters IDLE.
- o_frame_done pulses on the last V_BACK clock. o_frame_cnt increments on that same edge.
- o_busy = (state != IDLE).

## Timing
- All outputs are registered. Reset values: vsync 0, href 0, data 0, frame_done 0, frame_cnt 0, busy 0; state IDLE.
- A reset asserted at any point forces those values on the next edge. The partial frame is discarded and not counted.
- Frame start: the clock edge that samples i_enable=1 in IDLE launches the first VS_LOW clock (o_busy=1).
- Frame length is exactly (VSYNC_LOW + V_FRONT + V_ACTIVE + V_BACK) × H_TOTAL clocks.
- Back-to-back frames have no idle clocks. The vsync falling edge follows the last V_BACK clock directly.
- href and data are cycle-aligned. The first href-high clock of a line carries the x=0 pixel.
- Sinks detect end of frame as a vsync 1->0 transition.

## Test plan
Unless stated otherwise, use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=4, VSYNC_LOW=1, V_FRONT=1, V_BACK=1. This gives H_TOTAL=12 and 84 clocks per frame.

- **Basic frame, pattern 0.** Release reset, then hold i_enable=1 with sel=0.
  - vsync is low for 12 clocks, then high for 72.
  - href shows 4 bursts of 8 clocks spaced 12 apart, data 0..7 in each burst.
  - o_frame_done fires at clock 84; o_frame_cnt becomes 1.
- **Pattern 1.** Every pixel of active line n equals n (0,0,…; 1,1,…; 2…; 3…). Data is 0 in blanking.
- **Pattern 3, continuous.** Run 3 frames back-to-back with no gap between them.
  - Frame 2 first pixel is 1, frame 3 first pixel is 2.
  - o_frame_cnt reads 3; o_busy never drops.
- **Stop and pattern change.**
  - Drop i_enable at clock 30: the frame still ends at 84, then vsync, href, data and busy stay 0.
  - Change sel 0->1 mid-frame: the current frame keeps the ramp; the next frame uses pattern 1.
- **Reset mid-frame.** Assert i_rst_n=0 during the second active line.
  - All outputs are 0 on the next edge and o_frame_cnt is 0.
  - After release, a full 84-clock frame follows.
- **Wrap-around.** Preload or run until o_frame_cnt=0xFFFF; the next o_frame_done wraps it to 0.
- **Checkerboard, default parameters.** Pattern 2: line 0 x=0..7 is 0x00, x=8..15 is 0xFF; line 8 x=0..7 is 0xFF.
